// File: rtl/video_pixel_feeder.sv
// Pixel-clock consumer of the prefetch FIFO: pops one pixel per active-video cycle and re-times sync/DE/RGB.
// Latency: vs/hs/de/rgb outputs are exactly 1 clk after inputs; fifo_rd_en is combinational.
// Backpressure: the display cannot stall; an empty FIFO during DE outputs fill colour, flushes upstream and waits for the next frame.
module video_pixel_feeder #(
    parameter int                H_ACTIVE   = 1280,
    parameter int                V_ACTIVE   = 720,
    parameter int                DATA_W     = 16,
    parameter logic [DATA_W-1:0] FILL_COLOR = '0,
    parameter int                PIX_CNT_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vs_in,
    input  logic              hs_in,
    input  logic              de_in,
    input  logic              fifo_rd_vld,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_rd_en,
    output logic              fifo_flush,
    output logic              frame_start,
    output logic              vs_out,
    output logic              hs_out,
    output logic              de_out,
    output logic [DATA_W-1:0] rgb_out,
    output logic              underflow_err,
    output logic              short_frame_err,
    output logic [15:0]       underflow_cnt
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;
    localparam logic [1:0] ST_RESYNC = 2'd3;

    localparam logic [PIX_CNT_W-1:0] PIX_TOTAL = PIX_CNT_W'(H_ACTIVE * V_ACTIVE);

    logic [1:0]           state_q, state_d;
    logic [PIX_CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic                 vs_d1_q, hs_q, de_q;
    logic [DATA_W-1:0]    rgb_q, rgb_d;
    // armed_q masks the first cycle after reset so a vs already high at release is not an edge
    logic                 armed_q;
    logic                 frame_start_q, frame_start_d;
    logic                 flush_q, flush_d;
    logic                 uf_err_q, uf_err_d;
    logic                 short_err_q, short_err_d;
    logic [15:0]          uf_cnt_q, uf_cnt_d;

    logic                 vs_rise;
    logic                 pop;
    logic                 underrun;
    logic [PIX_CNT_W-1:0] pix_cnt_inc;
    logic [15:0]          uf_cnt_inc;

    // Edge detect, pop/underrun decode and next-state logic; vs edge outranks underrun and pops
    always_comb begin
        vs_rise       = vs_in & ~vs_d1_q & armed_q;
        pop           = (state_q == ST_ACTIVE) & de_in & fifo_rd_vld & ~vs_rise & ~rst;
        underrun      = (state_q == ST_ACTIVE) & de_in & ~fifo_rd_vld & ~vs_rise;
        pix_cnt_inc   = pix_cnt_q + PIX_CNT_W'(1);
        uf_cnt_inc    = (uf_cnt_q == 16'hFFFF) ? uf_cnt_q : uf_cnt_q + 16'd1;

        state_d       = state_q;
        pix_cnt_d     = pix_cnt_q;
        frame_start_d = 1'b0;
        flush_d       = 1'b0;
        uf_err_d      = uf_err_q;
        short_err_d   = short_err_q;
        uf_cnt_d      = uf_cnt_q;
        rgb_d         = pop ? fifo_rd_data : FILL_COLOR;

        if (vs_rise) begin
            frame_start_d = 1'b1;
            pix_cnt_d     = '0;
            state_d       = ST_ACTIVE;
            // a new frame while still consuming means the previous one came up short
            if (state_q == ST_ACTIVE) begin
                short_err_d = 1'b1;
                flush_d     = 1'b1;
            end
        end else begin
            case (state_q)
                ST_ACTIVE: begin
                    if (underrun) begin
                        uf_err_d = 1'b1;
                        uf_cnt_d = uf_cnt_inc;
                        flush_d  = 1'b1;
                        state_d  = ST_RESYNC;
                    end else if (pop) begin
                        pix_cnt_d = pix_cnt_inc;
                        if (pix_cnt_inc == PIX_TOTAL) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_RESYNC: begin
                    // every visible pixel lost while waiting for the next frame is counted
                    if (de_in) begin
                        uf_cnt_d = uf_cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pix_cnt_q     <= '0;
            vs_d1_q       <= 1'b0;
            hs_q          <= 1'b0;
            de_q          <= 1'b0;
            rgb_q         <= FILL_COLOR;
            armed_q       <= 1'b0;
            frame_start_q <= 1'b0;
            flush_q       <= 1'b0;
            uf_err_q      <= 1'b0;
            short_err_q   <= 1'b0;
            uf_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            pix_cnt_q     <= pix_cnt_d;
            vs_d1_q       <= vs_in;
            hs_q          <= hs_in;
            de_q          <= de_in;
            rgb_q         <= rgb_d;
            armed_q       <= 1'b1;
            frame_start_q <= frame_start_d;
            flush_q       <= flush_d;
            uf_err_q      <= uf_err_d;
            short_err_q   <= short_err_d;
            uf_cnt_q      <= uf_cnt_d;
        end
    end

    assign fifo_rd_en      = pop;
    assign fifo_flush      = flush_q;
    assign frame_start     = frame_start_q;
    assign vs_out          = vs_d1_q;
    assign hs_out          = hs_q;
    assign de_out          = de_q;
    assign rgb_out         = rgb_q;
    assign underflow_err   = uf_err_q;
    assign short_frame_err = short_err_q;
    assign underflow_cnt   = uf_cnt_q;

endmodule

// File: tb/tb_video_pixel_feeder.sv
// Randomized bench for video_pixel_feeder with a flag-based reference model and scoreboard.
// Stimulus task pushes expected next-cycle outputs; a negedge monitor pops and compares.
// Small frame geometry (4x2) keeps frames short; one long underflow run exercises saturation.
module tb_video_pixel_feeder;

    localparam int          H   = 4;
    localparam int          V   = 2;
    localparam int          TOT = H * V;
    localparam logic [15:0] FILL = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;
    logic        fifo_rd_vld = 1'b0;
    logic [15:0] fifo_rd_data = 16'h0000;
    logic        fifo_rd_en, fifo_flush, frame_start, vs_out, hs_out, de_out;
    logic [15:0] rgb_out;
    logic        underflow_err, short_frame_err;
    logic [15:0] underflow_cnt;

    video_pixel_feeder #(
        .H_ACTIVE(H), .V_ACTIVE(V), .DATA_W(16), .FILL_COLOR(FILL), .PIX_CNT_W(20)
    ) dut (
        .clk(clk), .rst(rst), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
        .fifo_rd_vld(fifo_rd_vld), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
        .fifo_flush(fifo_flush), .frame_start(frame_start), .vs_out(vs_out),
        .hs_out(hs_out), .de_out(de_out), .rgb_out(rgb_out),
        .underflow_err(underflow_err), .short_frame_err(short_frame_err),
        .underflow_cnt(underflow_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vs, hs, de, fs, fl;
        logic [15:0] rgb;
    } exp_t;

    exp_t        eq[$];
    logic [15:0] fq[$];
    int          checks = 0;
    int          fails  = 0;
    int          pops   = 0;

    // reference model: frame bookkeeping as plain flags and counts
    bit m_in_frame = 0, m_broken = 0, m_armed = 0, m_vs_prev = 0;
    bit m_uerr = 0, m_serr = 0;
    int m_got = 0, m_ucnt = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick(input logic vs, input logic hs, input logic de, input logic r);
        exp_t e;
        bit   pop, rise, streaming;
        @(negedge clk);
        #1;
        rst          = r;
        vs_in        = vs;
        hs_in        = hs;
        de_in        = de;
        fifo_rd_vld  = (fq.size() != 0);
        fifo_rd_data = (fq.size() != 0) ? fq[0] : 16'hDEAD;
        pop = 0;
        e.vs = vs; e.hs = hs; e.de = de; e.fs = 0; e.fl = 0; e.rgb = FILL;
        if (r) begin
            e.vs = 0; e.hs = 0; e.de = 0;
            m_in_frame = 0; m_broken = 0; m_armed = 0; m_vs_prev = 0;
            m_got = 0; m_uerr = 0; m_serr = 0; m_ucnt = 0;
        end else begin
            rise      = vs && !m_vs_prev && m_armed;
            streaming = m_in_frame && !m_broken && (m_got < TOT);
            if (rise) begin
                e.fs = 1;
                if (streaming) begin
                    m_serr = 1;
                    e.fl   = 1;
                end
                m_in_frame = 1; m_broken = 0; m_got = 0;
            end else if (streaming && de) begin
                if (fifo_rd_vld) begin
                    pop   = 1;
                    e.rgb = fifo_rd_data;
                    m_got++;
                end else begin
                    m_broken = 1;
                    m_uerr   = 1;
                    e.fl     = 1;
                    if (m_ucnt < 65535) m_ucnt++;
                end
            end else if (m_in_frame && m_broken && de) begin
                if (m_ucnt < 65535) m_ucnt++;
            end
            m_armed   = 1;
            m_vs_prev = vs;
        end
        eq.push_back(e);
        #1;
        checks++;
        if (fifo_rd_en !== pop) begin
            fails++;
            $display("FAIL rd_en got=%0b exp=%0b at %0t", fifo_rd_en, pop, $time);
        end
        if (fifo_rd_en === 1'b1) begin
            pops++;
            if (fq.size() != 0) void'(fq.pop_front());
        end
    endtask

    // monitor: every registered output cycle is checked against the scoreboard
    always @(negedge clk) begin : mon
        exp_t e;
        if (eq.size() != 0) begin
            e = eq.pop_front();
            chk("vs_out", vs_out, e.vs);
            chk("hs_out", hs_out, e.hs);
            chk("de_out", de_out, e.de);
            chk("rgb_out", rgb_out, e.rgb);
            chk("frame_start", frame_start, e.fs);
            chk("fifo_flush", fifo_flush, e.fl);
        end
    end

    task automatic run_de(input int n, input int maxgap);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            repeat ($urandom_range(0, maxgap)) tick(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
    endtask

    task automatic vs_pulse(input logic de_first);
        tick(1'b1, 1'b0, de_first, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic load_rand(input int n);
        for (int i = 0; i < n; i++) fq.push_back(16'($urandom_range(1, 16'hFFFE)));
    endtask

    task automatic chk_errs(input string nm);
        chk({nm, "_uerr"}, underflow_err, m_uerr);
        chk({nm, "_serr"}, short_frame_err, m_serr);
        chk({nm, "_ucnt"}, underflow_cnt, m_ucnt);
    endtask

    initial begin : stim
        int p0;
        // reset held with vs high, released with vs still high: no edge, no frame
        vs_in = 1'b1;
        repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_uerr", underflow_err, 0);
        chk("rst_ucnt", underflow_cnt, 0);
        for (int i = 1; i <= TOT; i++) fq.push_back(16'(i));
        p0 = pops;
        run_de(2, 1);
        chk("idle_pops", pops - p0, 0);

        // normal frame with the fixed 1..8 pattern
        vs_pulse(1'b0);
        p0 = pops;
        run_de(TOT, 2);
        chk("frame1_pops", pops - p0, TOT);
        chk_errs("frame1");
        chk("frame1_uerr_k", underflow_err, 0);

        // extra de cycles after completion
        p0 = pops;
        run_de(2, 1);
        chk("done_pops", pops - p0, 0);
        chk("done_serr_k", short_frame_err, 0);

        // underflow: 5 pixels for 8 de cycles
        load_rand(5);
        vs_pulse(1'b0);
        run_de(TOT, 1);
        chk_errs("uflow");
        chk("uflow_cnt_k", underflow_cnt, 3);

        // recovery frame
        load_rand(TOT);
        vs_pulse(1'b0);
        p0 = pops;
        run_de(TOT, 1);
        chk("recov_pops", pops - p0, TOT);

        // short frame: vs rises together with de after 6 pixels
        load_rand(TOT);
        vs_pulse(1'b0);
        run_de(6, 1);
        fq.delete();
        load_rand(TOT);
        vs_pulse(1'b1);
        p0 = pops;
        run_de(TOT, 2);
        chk("short_pops", pops - p0, TOT);
        chk_errs("short");
        chk("short_serr_k", short_frame_err, 1);

        // reset during pixel 3, no pops until next vs
        fq.delete();
        load_rand(TOT);
        vs_pulse(1'b0);
        run_de(2, 0);
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        p0 = pops;
        run_de(3, 1);
        chk("rstmid_pops", pops - p0, 0);
        chk_errs("rstmid");
        fq.delete();
        load_rand(TOT);
        vs_pulse(1'b0);
        p0 = pops;
        run_de(TOT, 1);
        chk("rstmid_next_pops", pops - p0, TOT);

        // saturation of the underflow counter
        fq.delete();
        vs_pulse(1'b0);
        run_de(70000, 0);
        chk_errs("sat");
        chk("sat_k", underflow_cnt, 16'hFFFF);

        tick(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", eq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/video_pixel_feeder.md
Name: video_pixel_feeder

Overview:
- Read-side consumer of the 256-to-16 prefetch FIFO in the pixel clock domain.
- Pops one 16-bit RGB565 pixel per active-video cycle of the display timing generator and re-times it with registered sync/DE.
- Emits a frame_start pulse so the DDR read controller begins fetching the next frame.
- Detects FIFO underflow and short frames, outputs fill colour, and resynchronises on the next frame.

Parameters:
H_ACTIVE, 1280, active pixels per line
V_ACTIVE, 720, active lines per frame
DATA_W, 16, pixel width; must equal FIFO read width
FILL_COLOR, 16'h0000, pixel value driven when no valid FIFO data is consumed
PIX_CNT_W, 20, pixel counter width; must satisfy 2^PIX_CNT_W > H_ACTIVE*V_ACTIVE

Ports:
clk  in  1  pixel clock, same clock as FIFO rd_clk
rst  in  1  synchronous active-high reset
vs_in  in  1  vertical sync from timing generator, active-high
hs_in  in  1  horizontal sync from timing generator, active-high
de_in  in  1  active-video enable from timing generator
fifo_rd_vld  in  1  FIFO rd_vld: fifo_rd_data is valid (show-ahead)
fifo_rd_data  in  DATA_W  FIFO head pixel
fifo_rd_en  out  1  pop strobe to FIFO rd_en; combinational
fifo_flush  out  1  one-cycle request to upstream to reset the FIFO/read controller
frame_start  out  1  one-cycle pulse: start fetching a frame
vs_out  out  1  vs_in delayed 1 clk
hs_out  out  1  hs_in delayed 1 clk
de_out  out  1  de_in delayed 1 clk
rgb_out  out  DATA_W  pixel aligned with de_out
underflow_err  out  1  sticky underflow flag
short_frame_err  out  1  sticky flag: vs arrived before frame complete
underflow_cnt  out  16  count of underflowed pixels, saturating at 16'hFFFF

Behaviour:
- Reset, synchronous on clk with rst=1:
  - All outputs 0; rgb_out = FILL_COLOR.
  - State = IDLE; pixel counter = 0; internal vs_in delay register = 0.
  - fifo_rd_en must be 0 during rst.
- vs_rise = vs_in & ~vs_in_d1. A vs already high when reset is released does not count as an edge.
- States:
  - IDLE: no pops. On vs_rise: pulse frame_start, clear counter, go ACTIVE.
  - ACTIVE: fifo_rd_en = de_in & fifo_rd_vld.
    - On a pop: next-cycle rgb_out = fifo_rd_data and the counter increments.
    - If de_in & ~fifo_rd_vld: rgb_out = FILL_COLOR, underflow_err set, underflow_cnt increments (saturating), fifo_flush pulses 1 cycle, go RESYNC.
    - When the counter reaches H_ACTIVE*V_ACTIVE (after the last pop), go DONE.
    - vs_rise while in ACTIVE (counter < total): short_frame_err set, fifo_flush and frame_start pulse in the same cycle, counter cleared, stay ACTIVE.
  - DONE: no pops; de_in cycles output FILL_COLOR. On vs_rise: frame_start pulse, counter cleared, go ACTIVE.
  - RESYNC: no pops; de_in cycles output FILL_COLOR, and each such cycle increments underflow_cnt. On vs_rise: frame_start pulse, counter cleared, go ACTIVE.
- Priority:
  - rst > vs_rise > underflow > normal pop.
  - vs_rise with de_in=1 in the same cycle: the transition is taken and no pop happens that cycle; rgb_out = FILL_COLOR.
- Latency:
  - vs_out, hs_out, de_out and rgb_out are exactly 1 clk after the corresponding inputs.
  - When de_out=0, rgb_out = FILL_COLOR.
- Pop rules:
  - fifo_rd_en is never asserted unless fifo_rd_vld=1.
  - At most one pop per clk.
- Counter compare uses PIX_CNT_W-bit unsigned arithmetic; the total is computed as a constant at elaboration.
- Sticky errors clear only on rst.

Test Plan:
- Normal frame (H_ACTIVE=4, V_ACTIVE=2), FIFO preloaded with 8 pixels 16'h0001..16'h0008, vs pulse then 2 lines of 4 de cycles -> frame_start 1 cycle after the vs edge cycle; rgb_out = 0001..0008 aligned with de_out one clk late; exactly 8 fifo_rd_en pulses; state DONE; no errors.
- Underflow: only 5 pixels available during 8 de cycles -> pixels 1..5 output, 6th de cycle outputs 16'h0000, fifo_flush 1 pulse, underflow_err=1, underflow_cnt=3 after frame; next vs_rise -> frame_start and pops resume.
- Short frame: vs_rise after 6 of 8 pixels -> short_frame_err=1, fifo_flush and frame_start in the same cycle; the following full frame of 8 pixels outputs correctly.
- Extra de after completion: 2 additional de cycles in DONE -> no fifo_rd_en, rgb_out=FILL_COLOR, no errors.
- Reset mid-frame: rst=1 for 1 clk during pixel 3 -> all outputs 0/FILL next cycle, fifo_rd_en=0; no pops until the next vs_rise, then frame_start.
- Saturation: force 70000 underflow de cycles in RESYNC -> underflow_cnt holds at 16'hFFFF.
